ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction queue entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_req_valid  output  1  fetch request to instruction memory.
REQ-006 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 mem_req_addr  output  32  word-aligned fetch address.
REQ-008 mem_rsp_valid  input  1  read data returned; responses are in request order, one per cycle maximum.
REQ-009 mem_rsp_data  input  32  instruction word.
REQ-010 inst_valid  output  1  instruction available to the core (drives the core's imem_out path).
REQ-011 inst_ready  input  1  core consumes the instruction this cycle.
REQ-012 inst_data  output  32  instruction word at the queue head.
REQ-013 inst_pc  output  32  address of inst_data.
REQ-014 redirect_valid  input  1  branch/jump/trap redirect from the core.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] are ignored (treated as 0).

Function
REQ-016 The block SHALL hold fetch_pc, increment it by 4 on each accepted request (mem_req_valid && mem_req_ready), and wrap 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 mem_req_addr SHALL equal fetch_pc; mem_req_addr SHALL stay stable while mem_req_valid && !mem_req_ready, except on redirect.
REQ-018 mem_req_valid SHALL be high iff (queue count + outstanding count) < DEPTH and the block is not in reset; outstanding counts accepted requests whose response has not yet arrived, including responses marked for dropping.
REQ-019 A response SHALL be written to the queue tail with its PC (captured from the request PC FIFO) and SHALL appear at inst_valid in the cycle after mem_rsp_valid (one-cycle latency, no bypass).
REQ-020 inst_valid SHALL be high iff the queue is non-empty; inst_data/inst_pc SHALL be the head entry; the head SHALL be popped when inst_valid && inst_ready.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged; a pop when full together with a push SHALL be legal.
REQ-022 On redirect_valid, the next cycle SHALL show an empty queue (inst_valid=0), fetch_pc = {redirect_pc[31:2],2'b00}, and drop_cnt = outstanding count after this cycle's accept/response accounting.
REQ-023 A pop and a redirect in the same cycle SHALL both take effect (the popped instruction counts as consumed).
REQ-024 A response arriving in the redirect cycle, or while drop_cnt > 0, SHALL be discarded and SHALL decrement drop_cnt/outstanding; it SHALL never reach inst_valid.
REQ-025 A request accepted in the redirect cycle SHALL be counted in drop_cnt.
REQ-026 New requests at the redirect target MAY issue from the cycle after the redirect, subject to REQ-018.
REQ-027 The state machine SHALL have the states RUN (normal) and DRAIN (drop_cnt > 0, requests still permitted); RUN->DRAIN on a redirect with non-zero outstanding; DRAIN->RUN when drop_cnt reaches 0; a redirect in DRAIN SHALL add the new outstanding count to drop_cnt.
REQ-028 A response with outstanding == 0 is a memory protocol error and SHALL be ignored (assertion in simulation).

Reset
REQ-029 While rst is low: mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_pc=RESET_PC, queue/outstanding/drop counts=0, state=RUN.
REQ-030 The first request SHALL be asserted in the first clock cycle after rst rises, with mem_req_addr=RESET_PC.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight fetches; responses after reset SHALL be ignored per REQ-028.

Structure
REQ-032 Shared package rv32_pkg SHALL hold RESET_PC default, the 32-bit word/address typedefs, and the fetch state enum.
REQ-033 The queue SHALL be a sub-module sync_fifo (data+PC, DEPTH entries, count output); the request PC FIFO SHALL be a second sync_fifo instance.

Verification
REQ-034 Reset release, memory ready=1, 1-cycle latency -> requests at 0x0,0x4,0x8,0xC; inst_pc sequence 0x0,0x4,... with matching data; first inst_valid 3 cycles after reset release.
REQ-035 inst_ready=0, memory always ready -> exactly DEPTH=4 requests issued, mem_req_valid drops, inst_valid held with inst_pc=0x0 unchanged.
REQ-036 Redirect to 0x103 with 2 responses outstanding -> both responses dropped, next request addr 0x100, first delivered inst_pc=0x100.
REQ-037 mem_req_ready=0 for 5 cycles -> mem_req_addr stable at 0x0 and mem_req_valid held high throughout.
REQ-038 Redirect to 0xFFFF_FFFC -> requests at 0xFFFF_FFFC then 0x0000_0000.
REQ-039 Pop and redirect in the same cycle, then rst low mid-stream -> popped instruction not repeated; all outputs at reset values while rst low.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types: word/address typedefs, fetch FSM states, queue entry payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    addr_t pc;
    word_t data;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic addr_t align_word(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, flush, and push-while-full when popping.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees the slot the same-cycle push needs, so full+pop+push is legal.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues word fetches, queues returned instructions with
// their PCs, and discards in-flight responses after a redirect.
module ifetch_queue
  import rv32_pkg::*;
#(
  parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic  clk,
  input  logic  rst,
  output logic  mem_req_valid,
  input  logic  mem_req_ready,
  output addr_t mem_req_addr,
  input  logic  mem_rsp_valid,
  input  word_t mem_rsp_data,
  output logic  inst_valid,
  input  logic  inst_ready,
  output word_t inst_data,
  output addr_t inst_pc,
  input  logic  redirect_valid,
  input  addr_t redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_e  state_q, state_d;
  addr_t         fetch_pc_q, fetch_pc_d;
  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] q_count, pc_count;
  logic [CW-1:0] oc_next, qc_next;
  fetch_entry_t  q_head, q_wdata;
  addr_t         rsp_pc;
  logic          accept, rsp_ok, rsp_drop, q_push, q_pop;

  assign accept   = req_valid_q && mem_req_ready;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_ok   = mem_rsp_valid && (pc_count != '0);
  assign rsp_drop = rsp_ok && (redirect_valid || (state_q == FETCH_DRAIN));
  assign q_push   = rsp_ok && !rsp_drop;
  assign q_pop    = (q_count != '0) && inst_ready;

  assign oc_next = pc_count + CW'(accept) - CW'(rsp_ok);
  assign qc_next = redirect_valid ? '0 : (q_count + CW'(q_push) - CW'(q_pop));
  // Registered so the request is withheld while in reset and appears one cycle after release.
  assign req_valid_d = ({1'b0, qc_next} + {1'b0, oc_next}) < (CW + 1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) fetch_pc_d = align_word(redirect_pc);
    case (state_q)
      FETCH_RUN: begin
        if (redirect_valid && (oc_next != '0)) begin
          drop_d  = oc_next;
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        // Every request still in flight after a redirect belongs to a stale stream.
        if (redirect_valid) drop_d = oc_next;
        else                drop_d = drop_q - CW'(rsp_drop);
        if (drop_d == '0) state_d = FETCH_RUN;
      end
      default: state_d = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH_RUN;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      drop_q      <= drop_d;
    end
  end

  // PCs of accepted requests, popped by every response whether kept or dropped.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_ok),
    .data_o  (rsp_pc),
    .count_o (pc_count)
  );

  assign q_wdata.pc   = rsp_pc;
  assign q_wdata.data = mem_rsp_data;

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_count)
  );

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign inst_valid    = (q_count != '0);
  assign inst_data     = q_head.data;
  assign inst_pc       = q_head.pc;

  rsp_needs_request: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> (pc_count != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: in-order memory model plus instruction-stream scoreboard.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } mem_item_t;

  mem_item_t   mq[$];     // requests accepted by memory, not yet answered
  logic [31:0] expq[$];   // PCs the core should still receive, in order
  int          arrived;   // delivered to the queue but not yet consumed
  int          epoch;
  int          cyc;
  logic [31:0] model_pc;
  bit          live;
  int          n_vec, n_err;

  int          p_ready, p_iready, p_rsp, p_redir;
  bit          redir_now, redir_if_valid, did_pop_redir, iv_at_neg;
  logic [31:0] redir_target;
  int          n_acc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced after the monitor has sampled.
  task automatic cycle();
    mem_item_t h;
    bit acc, pop, rsp;
    @(negedge clk);
    cyc++;
    iv_at_neg     = inst_valid;
    mem_req_ready = pct(p_ready);
    inst_ready    = pct(p_iready);
    redirect_valid = redir_now || (p_redir > 0 && pct(p_redir));
    if (redir_if_valid && inst_valid) begin
      redirect_valid = 1'b1;
      inst_ready     = 1'b1;
      did_pop_redir  = 1'b1;
    end
    redirect_pc   = (redir_now || redir_if_valid) ? redir_target : $urandom();
    rsp           = (mq.size() > 0) && (mq[0].rdy <= cyc) && pct(p_rsp);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom();
    #2;
    acc = mem_req_valid && mem_req_ready;
    pop = inst_valid && inst_ready;
    if (pop && arrived > 0) arrived--;
    if (rsp) begin
      h = mq.pop_front();
      if (h.epoch == epoch && !redirect_valid) arrived++;
    end
    if (acc) begin
      mq.push_back('{addr: mem_req_addr, epoch: epoch, rdy: cyc + 1});
      if (!redirect_valid) expq.push_back(model_pc);
      n_acc++;
    end
    if (redirect_valid) begin
      arrived = 0;
      expq.delete();
      epoch++;
      model_pc = {redirect_pc[31:2], 2'b00};
    end else if (acc) begin
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic reset_checks();
    chk("rst_req_valid",  {31'b0, mem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid},    32'd0);
    chk("rst_inst_data",  inst_data,              32'd0);
    chk("rst_inst_pc",    inst_pc,                32'd0);
    chk("rst_req_addr",   mem_req_addr,           RESET_PC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    live = 1'b0;
    mem_req_ready = 1'b0; inst_ready = 1'b0; mem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    mq.delete(); expq.delete();
    arrived = 0; epoch++; model_pc = RESET_PC;
    repeat (2) begin
      #1 reset_checks();
      @(negedge clk);
    end
    rst = 1'b1;
    #2 live = 1'b1;
  endtask

  // Scoreboard monitor: compares every consumed instruction and the flow-control outputs.
  always begin
    logic [31:0] e;
    @(negedge clk);
    #1;
    if (rst && live) begin
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, arrived != 0});
      chk("req_valid", {31'b0, mem_req_valid}, {31'b0, (arrived + mq.size()) < DEPTH});
      chk("req_addr", mem_req_addr, model_pc);
      if (inst_valid && inst_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_inst_pc", inst_pc, 32'hDEAD_DEAD);
        end else begin
          e = expq.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst_data", inst_data, memf(e));
        end
      end
    end
  end

  initial begin
    int first;
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; arrived = 0; live = 1'b0;
    redir_now = 1'b0; redir_if_valid = 1'b0; redir_target = '0; model_pc = RESET_PC;
    p_redir = 0;

    // Streaming: addresses 0,4,8,... delivered in order; first instruction 3 cycles after release.
    p_ready = 100; p_iready = 100; p_rsp = 100;
    do_reset();
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (first == 0 && iv_at_neg) first = k;
    end
    chk("first_valid_latency", 32'(first), 32'd3);

    // Core stalled: exactly DEPTH requests, then the queue holds at RESET_PC.
    p_iready = 0;
    do_reset();
    n_acc = 0;
    repeat (12) cycle();
    chk("stall_acc_count", 32'(n_acc), 32'(DEPTH));
    chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_inst_pc", inst_pc, RESET_PC);

    // Memory not ready: request held stable.
    p_ready = 0; p_iready = 100;
    do_reset();
    repeat (5) begin
      cycle();
      chk("hold_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("hold_req_addr", mem_req_addr, RESET_PC);
    end

    // Redirect with two responses outstanding.
    p_ready = 100; p_rsp = 0;
    do_reset();
    for (int k = 0; k < 10 && mq.size() < 2; k++) cycle();
    chk("pre_redirect_outstanding", 32'(mq.size()), 32'd2);
    p_ready = 0; redir_now = 1'b1; redir_target = 32'h0000_0103;
    cycle();
    redir_now = 1'b0; p_ready = 100; p_rsp = 100;
    first = 0;
    for (int k = 0; k < 20 && first == 0; k++) begin
      cycle();
      if (iv_at_neg) begin
        first = 1;
        chk("redirect_first_pc", inst_pc, 32'h0000_0100);
      end
    end
    chk("redirect_delivered", 32'(first), 32'd1);

    // Redirect to the top word: fetch wraps to zero.
    redir_now = 1'b1; redir_target = 32'hFFFF_FFFE;
    cycle();
    redir_now = 1'b0;
    repeat (10) cycle();

    // Pop and redirect in one cycle, then reset mid-stream.
    redir_if_valid = 1'b1; redir_target = 32'h0000_2000; did_pop_redir = 1'b0;
    for (int k = 0; k < 20 && !did_pop_redir; k++) cycle();
    redir_if_valid = 1'b0;
    chk("pop_redirect_seen", {31'b0, did_pop_redir}, 32'd1);
    repeat (6) cycle();
    do_reset();
    repeat (8) cycle();

    // Random traffic.
    p_ready = 70; p_iready = 60; p_rsp = 60; p_redir = 3;
    repeat (3000) cycle();

    // Drain: everything fetched must reach the core.
    p_ready = 0; p_iready = 100; p_rsp = 100; p_redir = 0;
    repeat (20) cycle();
    chk("drain_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
